wb_port_arbiter: RTL and testbench

- Shares the single register-file write port between two writeback requesters: requester 0 (ALU/R-type result) and requester 1 (load/memory result).
- Drives the select line of the shared 5-bit 2:1 register-destination mux and the register-file write enable.
- Grants with registered, one-cycle write slots.
- Filters writes to $0 and counts contention cycles for performance debug.

---
 rtl/wb_port_arbiter_pkg.sv | 21 ++
 rtl/wb_rr_pick.sv | 30 +++
 rtl/wb_port_arbiter.sv | 108 ++++++++++
 tb/tb_wb_port_arbiter.sv | 130 +++++++++++++
 4 files changed

// File: rtl/wb_port_arbiter_pkg.sv
// Shared definitions for the writeback port arbiter.
// Holds default widths, the $0 register index, FSM state encoding and
// requester index constants used by the top and the picker.
package wb_port_arbiter_pkg;

    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned CNT_W_DEF  = 8;

    // Index of the hard-wired zero register; writes to it are suppressed.
    localparam int unsigned REG_ZERO = 0;

    // Requester indices; also the value driven on the mux select.
    localparam logic REQ_ALU = 1'b0;
    localparam logic REQ_MEM = 1'b1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SLOT = 1'b1
    } state_t;

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational 2-way picker for the writeback arbiter.
// Ports:
//   elig     - eligible bits, [0] = ALU requester, [1] = MEM requester
//   last     - requester that won the previous grant
//   winner_c - selected requester index
//   valid_c  - at least one requester is eligible
// With RR = 1 a tie goes to the requester that did not win last;
// with RR = 0 a tie always goes to the ALU requester.
module wb_rr_pick
    import wb_port_arbiter_pkg::*;
#(
    parameter bit RR = 1'b1
) (
    input  logic [1:0] elig,
    input  logic       last,
    output logic       winner_c,
    output logic       valid_c
);

    always_comb begin
        winner_c = REQ_ALU;
        valid_c  = |elig;
        if (elig == 2'b11) begin
            winner_c = RR ? ~last : REQ_ALU;
        end else if (elig[1]) begin
            winner_c = REQ_MEM;
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbiter for the single register-file write port shared by the ALU
// writeback (requester 0) and the load writeback (requester 1).
// Ports:
//   clk, rst        - clock and synchronous active-high reset
//   req0/addr0      - ALU write request and destination register
//   req1/addr1      - load write request and destination register
//   stall           - port unavailable; no new grant is decided
//   gnt0/gnt1       - one-cycle write slot owned by requester 0/1
//   sel             - destination/data mux select (holds in idle)
//   wr_en           - register-file write enable, suppressed for $0
//   coll_cnt        - saturating count of edges with both requesters eligible
// A winner decided at one edge owns the following cycle; all outputs are
// registered.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter bit          RR     = 1'b1,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic              stall,
    output logic              gnt0,
    output logic              gnt1,
    output logic              sel,
    output logic              wr_en,
    output logic [CNT_W-1:0]  coll_cnt
);

    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [ADDR_W-1:0] ZERO_REG = ADDR_W'(REG_ZERO);

    state_t     state;
    logic       last;
    logic [1:0] elig_c;
    logic       win_c;
    logic       win_valid_c;
    logic       grant_c;
    logic       both_c;
    logic       nz0_c;
    logic       nz1_c;

    // A request seen during its own slot is the transaction being served.
    always_comb begin
        elig_c = {req1, req0};
        case (state)
            ST_SLOT: elig_c = {req1 & ~gnt1, req0 & ~gnt0};
            default: elig_c = {req1, req0};
        endcase
    end

    assign both_c  = &elig_c;
    assign nz0_c   = (addr0 != ZERO_REG);
    assign nz1_c   = (addr1 != ZERO_REG);
    assign grant_c = win_valid_c & ~stall;

    wb_rr_pick #(
        .RR (RR)
    ) u_pick (
        .elig     (elig_c),
        .last     (last),
        .winner_c (win_c),
        .valid_c  (win_valid_c)
    );

    // FSM, round-robin pointer, registered slot outputs and collision counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            last     <= REQ_MEM;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            sel      <= REQ_ALU;
            wr_en    <= 1'b0;
            coll_cnt <= '0;
        end else begin
            if (both_c && (coll_cnt != CNT_MAX)) begin
                coll_cnt <= coll_cnt + CNT_W'(1);
            end

            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            wr_en <= 1'b0;

            case (state)
                ST_IDLE, ST_SLOT: begin
                    if (grant_c) begin
                        state <= ST_SLOT;
                        last  <= win_c;
                        sel   <= win_c;
                        gnt0  <= (win_c == REQ_ALU);
                        gnt1  <= (win_c == REQ_MEM);
                        wr_en <= (win_c == REQ_MEM) ? nz1_c : nz0_c;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: a round-robin instance (A) and a
// fixed-priority instance (B) share stimulus; each step queues the
// expected outputs of both for the following cycle and checks them.
module tb_wb_port_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1, stall;
    logic [4:0] addr0, addr1;

    logic       gnt0_a, gnt1_a, sel_a, wr_en_a;
    logic [7:0] cnt_a;
    logic       gnt0_b, gnt1_b, sel_b, wr_en_b;
    logic [7:0] cnt_b;

    int checks = 0;
    int passes = 0;

    typedef struct {
        string       tag;
        logic [11:0] exp_a;
        logic [11:0] exp_b;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    wb_port_arbiter #(.ADDR_W(5), .RR(1'b1), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst),
        .req0(req0), .addr0(addr0), .req1(req1), .addr1(addr1), .stall(stall),
        .gnt0(gnt0_a), .gnt1(gnt1_a), .sel(sel_a), .wr_en(wr_en_a), .coll_cnt(cnt_a)
    );

    wb_port_arbiter #(.ADDR_W(5), .RR(1'b0), .CNT_W(8)) dut_b (
        .clk(clk), .rst(rst),
        .req0(req0), .addr0(addr0), .req1(req1), .addr1(addr1), .stall(stall),
        .gnt0(gnt0_b), .gnt1(gnt1_b), .sel(sel_b), .wr_en(wr_en_b), .coll_cnt(cnt_b)
    );

    function automatic logic [11:0] mk(logic g0, logic g1, logic s, logic w, logic [7:0] c);
        return {g0, g1, s, w, c};
    endfunction

    // Drive one cycle of inputs, queue expectations, compare after the edge.
    task automatic step(input string tag,
                        input logic r0, input logic [4:0] a0,
                        input logic r1, input logic [4:0] a1,
                        input logic st, input logic rs,
                        input logic [11:0] ea, input logic [11:0] eb);
        exp_t e;
        logic [11:0] obs_a, obs_b;
        req0 = r0; addr0 = a0; req1 = r1; addr1 = a1; stall = st; rst = rs;
        sb.push_back('{tag: tag, exp_a: ea, exp_b: eb});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        obs_a = {gnt0_a, gnt1_a, sel_a, wr_en_a, cnt_a};
        obs_b = {gnt0_b, gnt1_b, sel_b, wr_en_b, cnt_b};
        checks++;
        assert (obs_a === e.exp_a) passes++;
        else $error("FAIL %s rr1 {g0,g1,sel,wr,cnt} observed=%h expected=%h", e.tag, obs_a, e.exp_a);
        checks++;
        assert (obs_b === e.exp_b) passes++;
        else $error("FAIL %s fixed {g0,g1,sel,wr,cnt} observed=%h expected=%h", e.tag, obs_b, e.exp_b);
    endtask

    initial begin
        logic [11:0] z;
        logic [7:0]  c;
        z = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0; stall = 1'b0; rst = 1'b1;

        step("reset0", 0, 0, 0, 0, 0, 1, z, z);
        step("reset1", 0, 0, 0, 0, 0, 1, z, z);

        // single request, held through its slot, then dropped
        step("single",      1, 5, 0, 0, 0, 0, mk(1,0,0,1,0), mk(1,0,0,1,0));
        step("single_hold", 1, 5, 0, 0, 0, 0, z, z);
        step("single_idle", 0, 0, 0, 0, 0, 0, z, z);

        // tie with last = 0: RR picks 1, fixed picks 0, then alternation
        step("tie",   1, 3, 1, 7, 0, 0, mk(0,1,1,1,1), mk(1,0,0,1,1));
        step("alt1",  1, 3, 1, 7, 0, 0, mk(1,0,0,1,1), mk(0,1,1,1,1));
        step("alt2",  1, 3, 1, 7, 0, 0, mk(0,1,1,1,1), mk(1,0,0,1,1));
        step("alt3",  1, 3, 1, 7, 0, 0, mk(1,0,0,1,1), mk(0,1,1,1,1));

        // stall with both pending: no grants, counter climbs and saturates
        step("stall_both", 1, 3, 1, 7, 1, 0, mk(0,0,0,0,1), mk(0,0,1,0,1));
        for (int i = 0; i < 300; i++) begin
            c = (i + 2 > 255) ? 8'd255 : 8'(i + 2);
            step("sat", 1, 3, 1, 7, 1, 0, mk(0,0,0,0,c), mk(0,0,1,0,c));
        end
        step("release", 1, 3, 1, 7, 0, 0, mk(0,1,1,1,255), mk(1,0,0,1,255));

        // reset during a gnt1 slot of instance A
        step("rst_mid_slot", 1, 3, 1, 7, 0, 1, z, z);
        step("post_rst",     0, 0, 0, 0, 0, 0, z, z);

        // write to $0: granted but no write enable
        step("zero_addr",      0, 0, 1, 0, 0, 0, mk(0,1,1,0,0), mk(0,1,1,0,0));
        step("zero_addr_hold", 0, 0, 1, 0, 0, 0, mk(0,0,1,0,0), mk(0,0,1,0,0));

        // stall for 3 cycles with req0 pending, then grant after release
        step("stall1", 1, 9, 0, 0, 1, 0, mk(0,0,1,0,0), mk(0,0,1,0,0));
        step("stall2", 1, 9, 0, 0, 1, 0, mk(0,0,1,0,0), mk(0,0,1,0,0));
        step("stall3", 1, 9, 0, 0, 1, 0, mk(0,0,1,0,0), mk(0,0,1,0,0));
        step("unstall", 1, 9, 0, 0, 0, 0, mk(1,0,0,1,0), mk(1,0,0,1,0));

        // stall rising during an already granted slot does not cancel it
        stall = 1'b1;
        #1;
        checks++;
        assert ({gnt0_a, wr_en_a, gnt0_b, wr_en_b} === 4'b1111) passes++;
        else $error("FAIL slot_under_stall observed=%b expected=1111", {gnt0_a, wr_en_a, gnt0_b, wr_en_b});
        step("slot_end_stall", 1, 9, 0, 0, 1, 0, z, z);
        step("drop",           0, 0, 0, 0, 0, 0, z, z);

        // lone requester re-presenting: one slot every other cycle
        step("solo_g1", 1, 4, 0, 0, 0, 0, mk(1,0,0,1,0), mk(1,0,0,1,0));
        step("solo_i1", 1, 4, 0, 0, 0, 0, z, z);
        step("solo_g2", 1, 4, 0, 0, 0, 0, mk(1,0,0,1,0), mk(1,0,0,1,0));
        step("solo_i2", 1, 4, 0, 0, 0, 0, z, z);
        step("solo_end", 0, 0, 0, 0, 0, 0, z, z);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
